// File: rtl/ctr_pkg.sv
// Shared types for the ctr counter and its command sequencer, so mode
// encodings and command layout cannot drift apart between blocks.
package ctr_pkg;

    localparam int CTR_BITS = 3;
    localparam int CTR_LENW = 4;

    typedef enum logic [1:0] {
        HOLD = 2'b00,
        LOAD = 2'b01,
        UP   = 2'b10,
        DOWN = 2'b11
    } ctr_mode_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    typedef struct packed {
        ctr_mode_t             mode;
        logic [CTR_BITS-1:0]   data;
        logic [CTR_LENW-1:0]   len;
    } ctr_cmd_t;

endpackage

// File: rtl/ctr_cmd_fifo.sv
// Small synchronous FIFO holding queued sequencer commands. Status flags
// come from the registered count only, so a push is never visible to the
// reader before the following edge.
module ctr_cmd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage is not reset; pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ctr_seq.sv
// Command sequencer for the ctr counter: buffers {mode, data, len} commands
// and replays each one onto the counter inputs for len+1 cycles.
module ctr_seq
    import ctr_pkg::*;
#(
    parameter int BITS  = 3,
    parameter int LENW  = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_mode,
    input  logic [BITS-1:0] cmd_data,
    input  logic [LENW-1:0] cmd_len,
    output ctr_mode_t       mode_out,
    output logic [BITS-1:0] data_out,
    output logic            busy,
    output logic            cmd_done
);

    localparam int W = 2 + BITS + LENW;

    // Handshake: a command transfers on any rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends only on registered FIFO
    // state, and the producer holds its fields while waiting.
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [W-1:0]    fifo_head;
    ctr_mode_t       head_mode;
    logic [BITS-1:0] head_data;
    logic [LENW-1:0] head_len;

    seq_state_t      state;
    logic [LENW-1:0] remaining;

    ctr_cmd_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid && cmd_ready),
        .pop   (fifo_pop),
        .wdata ({cmd_mode, cmd_data, cmd_len}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign head_mode = ctr_mode_t'(fifo_head[W-1 -: 2]);
    assign head_data = fifo_head[LENW +: BITS];
    assign head_len  = fifo_head[LENW-1:0];

    assign cmd_ready = !fifo_full;
    assign busy      = (state == RUN);
    assign cmd_done  = (state == RUN) && (remaining == '0);

    // A new command is taken whenever nothing is in progress or the current
    // one is in its last cycle, which gives gap-free back-to-back replay.
    assign fifo_pop = !fifo_empty && ((state == IDLE) || (remaining == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            mode_out  <= HOLD;
            data_out  <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state     <= RUN;
                        mode_out  <= head_mode;
                        data_out  <= head_data;
                        remaining <= head_len;
                    end
                end
                RUN: begin
                    if (remaining != '0) begin
                        remaining <= remaining - LENW'(1);
                    end else if (!fifo_empty) begin
                        mode_out  <= head_mode;
                        data_out  <= head_data;
                        remaining <= head_len;
                    end else begin
                        state    <= IDLE;
                        mode_out <= HOLD;
                        data_out <= '0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mode_out <= HOLD;
                    data_out <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_seq.sv
// Self-checking bench for ctr_seq: directed commands feed an expected-output
// queue that a negedge monitor drains, with a small ctr model downstream.
module tb_ctr_seq;
    import ctr_pkg::*;

    localparam int BITS  = 3;
    localparam int LENW  = 4;
    localparam int DEPTH = 4;

    logic            clk       = 1'b0;
    logic            rst_n     = 1'b0;
    logic            cmd_valid = 1'b0;
    logic [1:0]      cmd_mode  = 2'b00;
    logic [BITS-1:0] cmd_data  = '0;
    logic [LENW-1:0] cmd_len   = '0;
    logic            cmd_ready;
    ctr_mode_t       mode_out;
    logic [BITS-1:0] data_out;
    logic            busy;
    logic            cmd_done;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int done_cnt     = 0;

    logic [5:0]      exp_q[$];
    logic [BITS-1:0] ctr_log[$];
    logic [BITS-1:0] ctr_q    = '0;
    bit              prev_more = 1'b0;
    bit              prev_busy = 1'b0;
    bit              log_ctr   = 1'b0;

    ctr_seq #(
        .BITS  (BITS),
        .LENW  (LENW),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .mode_out  (mode_out),
        .data_out  (data_out),
        .busy      (busy),
        .cmd_done  (cmd_done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    // Downstream counter model, driven by the sequencer outputs.
    always @(posedge clk) begin
        case (mode_out)
            LOAD:    ctr_q <= data_out;
            UP:      ctr_q <= ctr_q + 3'd1;
            DOWN:    ctr_q <= ctr_q - 3'd1;
            default: ctr_q <= ctr_q;
        endcase
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Drives one command and returns the cycle stamp of its acceptance edge.
    task automatic push_cmd(input logic [1:0] m, input logic [BITS-1:0] d,
                            input logic [LENW-1:0] l, input bit sync, output int at);
        int budget;
        budget = 0;
        if (sync) @(negedge clk);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_data  = d;
        cmd_len   = l;
        while (!cmd_ready && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (!cmd_ready) begin
            fail_now("push_timeout");
            cmd_valid = 1'b0;
            at = -1;
            return;
        end
        @(posedge clk);
        at = cyc;
        for (int i = 0; i <= int'(l); i++) begin
            exp_q.push_back({m, d, (i == int'(l))});
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || busy) && b < 500) begin
            @(negedge clk);
            b++;
        end
        if (b >= 500) fail_now("drain_timeout");
        @(negedge clk);
        @(negedge clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [5:0] e;
        if (!rst_n) begin
            prev_more = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (log_ctr && prev_busy) ctr_log.push_back(ctr_q);
            if (busy) begin
                if (cmd_done) done_cnt++;
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_output");
                    prev_more = 1'b0;
                end else begin
                    e = exp_q.pop_front();
                    check("sb_out", {26'd0, mode_out, data_out, cmd_done}, {26'd0, e});
                    prev_more = !e[0];
                end
            end else begin
                if (prev_more) fail_now("hold_gap");
                prev_more = 1'b0;
            end
            prev_busy = busy;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int at;
        int ats[6];
        int busy_seen;
        int b;
        logic [BITS-1:0] exp_ctr[7];
        int full_off[6];

        exp_ctr  = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0};
        full_off = '{0, 1, 2, 3, 4, 18};

        // Reset
        @(negedge clk);
        @(negedge clk);
        check("rst_mode", mode_out, HOLD);
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", cmd_done, 0);
        check("rst_ready", cmd_ready, 1);
        rst_n = 1'b1;

        // Single command, exact latency
        push_cmd(LOAD, 3'd5, 4'd0, 1'b1, at);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("single_no_bypass_busy", busy, 0);
        check("single_no_bypass_mode", mode_out, HOLD);
        @(negedge clk);
        check("single_mode", mode_out, LOAD);
        check("single_data", data_out, 5);
        check("single_done", cmd_done, 1);
        @(negedge clk);
        check("single_after_mode", mode_out, HOLD);
        check("single_after_data", data_out, 0);
        check("single_after_busy", busy, 0);
        drain();

        // Back-to-back with counter attached
        ctr_log.delete();
        done_cnt = 0;
        log_ctr  = 1'b1;
        push_cmd(LOAD, 3'd6, 4'd0, 1'b1, at);
        push_cmd(UP,   3'd0, 4'd3, 1'b1, at);
        push_cmd(DOWN, 3'd0, 4'd1, 1'b1, at);
        idle_in();
        drain();
        log_ctr = 1'b0;
        check("b2b_ctr_len", ctr_log.size(), 7);
        for (int i = 0; i < 7 && i < ctr_log.size(); i++) begin
            check("b2b_ctr_val", ctr_log[i], exp_ctr[i]);
        end
        check("b2b_done_pulses", done_cnt, 3);

        // Full FIFO: six long commands with valid held high
        for (int i = 0; i < 5; i++) begin
            push_cmd(UP, 3'(i + 1), 4'd15, 1'b1, ats[i]);
        end
        @(negedge clk);
        check("full_ready_low", cmd_ready, 0);
        push_cmd(DOWN, 3'd6, 4'd15, 1'b0, ats[5]);
        idle_in();
        for (int i = 0; i < 6; i++) begin
            check("full_accept_edge", ats[i] - ats[0], full_off[i]);
        end
        drain();

        // Mid-command reset with three commands queued
        push_cmd(UP,   3'd1, 4'd5, 1'b1, at);
        push_cmd(LOAD, 3'd2, 4'd0, 1'b1, at);
        push_cmd(LOAD, 3'd3, 4'd0, 1'b1, at);
        push_cmd(LOAD, 3'd4, 4'd0, 1'b1, at);
        @(negedge clk);
        check("midrst_busy_before", busy, 1);
        rst_n     = 1'b0;
        cmd_valid = 1'b1;
        cmd_mode  = LOAD;
        cmd_data  = 3'd7;
        cmd_len   = 4'd0;
        exp_q.delete();
        @(negedge clk);
        check("midrst_mode", mode_out, HOLD);
        check("midrst_data", data_out, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", cmd_done, 0);
        check("midrst_ready", cmd_ready, 1);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("midrst_no_replay", busy_seen, 0);

        // Simultaneous push and pop at count 3
        push_cmd(UP,   3'd1, 4'd3, 1'b1, ats[0]);
        push_cmd(DOWN, 3'd2, 4'd3, 1'b1, ats[1]);
        push_cmd(LOAD, 3'd3, 4'd3, 1'b1, ats[2]);
        push_cmd(UP,   3'd4, 4'd3, 1'b1, ats[3]);
        @(negedge clk);
        cmd_valid = 1'b0;
        b = 0;
        while (!cmd_done && b < 50) begin
            @(negedge clk);
            b++;
        end
        if (b >= 50) fail_now("pushpop_wait_timeout");
        push_cmd(DOWN, 3'd5, 4'd3, 1'b0, ats[4]);
        check("pushpop_edge", ats[4] - ats[3], 2);
        push_cmd(LOAD, 3'd6, 4'd3, 1'b1, ats[5]);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("pushpop_full_after", cmd_ready, 0);
        drain();
        check("sb_empty_end", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ctr_seq.md
# ctr_seq

Command sequencer that sits directly upstream of the `ctr` counter and drives its `mode_in`/`data_in` inputs. Commands (mode, load value, duration) arrive over a valid/ready handshake, are buffered in a small FIFO, and are replayed to the counter one at a time. Each command is held for a programmed number of cycles. The counter therefore runs scripted up/down/load/hold sequences without cycle-exact driving from the producer.

## Interface

- `BITS`, 3, data width; must equal the `ctr` `BITS`.
- `LENW`, 4, width of the command duration field.
- `DEPTH`, 4, FIFO depth in entries; power of 2, ≥ 2.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cmd_valid`  in  1  producer has a command.
- `cmd_ready`  out  1  FIFO can accept a command.
- `cmd_mode`  in  2  counter mode (`ctr_mode_t`).
- `cmd_data`  in  BITS  value presented to the counter for the command's duration.
- `cmd_len`  in  LENW  duration minus one: the command is applied for `cmd_len`+1 cycles.
- `mode_out`  out  2  connects to `ctr.mode_in`.
- `data_out`  out  BITS  connects to `ctr.data_in`.
- `busy`  out  1  a command is being applied.
- `cmd_done`  out  1  high during the last applied cycle of each command.

## Operation

- Mode encoding is fixed: HOLD=2'b00, LOAD=2'b01, UP=2'b10, DOWN=2'b11.
- Handshake:
  - Push occurs when `cmd_valid && cmd_ready`.
  - `cmd_ready` = !full, registered-state derived only, with no combinational path from `cmd_valid`.
  - The producer keeps its fields stable while `cmd_valid` is high and `cmd_ready` is low.
- FIFO:
  - `DEPTH` entries, each holding {mode, data, len}.
  - Count width is clog2(`DEPTH`)+1.
  - Pointers wrap modulo `DEPTH`.
  - Simultaneous push and pop leaves the count unchanged.
  - When full, `cmd_ready` is low, so no push can occur even if a pop happens that cycle.
  - No bypass: a pushed entry can be popped no earlier than the following edge.
- FSM states: IDLE, RUN.
- IDLE:
  - Outputs are `mode_out`=HOLD, `data_out`=0, `busy`=0.
  - If the FIFO is not empty: pop the head, register its mode and data onto the outputs, load `remaining`=len, go to RUN.
- RUN:
  - Outputs hold the current command.
  - If `remaining`≠0: decrement `remaining`.
  - If `remaining`==0 and the FIFO is not empty: pop the next entry and load it. Back-to-back commands have no HOLD gap.
  - If `remaining`==0 and the FIFO is empty: go to IDLE; outputs become HOLD/0 on the same edge.
- `cmd_done` = (state==RUN && `remaining`==0).
- `busy` = (state==RUN).
- `remaining` is LENW bits wide and never underflows.
- Reset (synchronous, applies at any time, including mid-command):
  - FIFO is flushed (pointers and count to 0) and queued commands are discarded.
  - State goes to IDLE; `mode_out`=HOLD, `data_out`=0, `busy`=0, `cmd_done`=0, `cmd_ready`=1 after the reset edge.
  - A push attempted during reset is ignored.

## Timing

- `mode_out` and `data_out` are registered outputs.
- A command accepted at edge N into an empty, idle block appears on the outputs after edge N+1. Those outputs are sampled by `ctr` at edge N+2.
- A command with length L occupies exactly L+1 consecutive output cycles.
- `cmd_ready` drops in the cycle after the push that filled the FIFO. It rises in the cycle after the first pop from full.

## Structure

- Package `ctr_pkg`:
  - `ctr_mode_t` enum (HOLD/LOAD/UP/DOWN); shared with `ctr` so encodings cannot diverge.
  - `seq_state_t` enum (IDLE/RUN).
  - Packed struct `ctr_cmd_t` {mode, data, len}, parameterised through localparams matching `BITS`/`LENW` defaults.
- Sub-module `ctr_cmd_fifo`:
  - Synchronous FIFO with parameters `WIDTH` and `DEPTH`.
  - Ports: push/pop, full/empty, head data.
  - `ctr_seq` instantiates it once and contains only the FSM and output registers.

## Test plan

- Reset: hold `rst_n`=0 for 2 negedges → `mode_out`=HOLD, `data_out`=0, `busy`=0, `cmd_done`=0, `cmd_ready`=1.
- Single command: push {LOAD, 5, len 0} at edge N → `mode_out`=LOAD and `data_out`=5 only in cycle N+1 with `cmd_done`=1 → HOLD/0 from N+2.
- Back-to-back with `ctr` attached:
  - Stimulus: push {LOAD,6,0}, {UP,0,3}, {DOWN,0,1}.
  - Outputs: LOAD for 1 cycle, UP for 4, DOWN for 2, no HOLD cycles between them.
  - `ctr` `data_out` sequence: 6,7,0,1,2,1,0 (wrap at 8); `cmd_done` pulses 3 times.
- Full FIFO:
  - Stimulus: `cmd_valid` held high with 6 commands of len 15 starting at edge 1.
  - Accepted: A at edge 1, B–E at edges 2–5; `cmd_ready`=0 from cycle 6.
  - F is accepted the cycle after B is popped (edge 18).
- Mid-command reset: assert `rst_n`=0 during RUN with 3 entries queued → after the reset edge, HOLD/0, `busy`=0, `cmd_ready`=1; after release, no queued command ever appears.
- Simultaneous push/pop: at count 3, pop and push on the same edge → count stays 3 and order is preserved (checked via the output sequence).
